// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one memory port between instruction fetch and data access.
// Data wins by default; a starvation counter forces a fetch through after STARVE_MAX data wins.
module riscv_mem_arbiter #(
    parameter int WORD_SIZE  = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   if_req_i,
    input  logic [WORD_SIZE-1:0]   if_addr_i,
    input  logic                   if_flush_i,
    output logic                   if_gnt_o,
    output logic                   if_rvalid_o,
    output logic [WORD_SIZE-1:0]   if_rdata_o,
    input  logic                   dm_req_i,
    input  logic                   dm_we_i,
    input  logic [WORD_SIZE/8-1:0] dm_be_i,
    input  logic [WORD_SIZE-1:0]   dm_addr_i,
    input  logic [WORD_SIZE-1:0]   dm_wdata_i,
    output logic                   dm_gnt_o,
    output logic                   dm_rvalid_o,
    output logic [WORD_SIZE-1:0]   dm_rdata_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [WORD_SIZE/8-1:0] mem_be_o,
    output logic [WORD_SIZE-1:0]   mem_addr_o,
    output logic [WORD_SIZE-1:0]   mem_wdata_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [WORD_SIZE-1:0]   mem_rdata_i
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
    typedef enum logic {OWN_IF, OWN_DM} owner_e;

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          drop_q, drop_d;

    owner_e sel;
    logic   req_live;
    logic   gnt_live;
    logic   rsp_fire;
    logic   if_owns;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            starve_cnt_q <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            drop_q       <= drop_d;
        end
    end

    // In IDLE the winner is picked live; once locked in REQ/WAIT the owner register decides.
    always_comb begin
        sel      = owner_q;
        req_live = 1'b0;
        if (state_q == IDLE) begin
            req_live = if_req_i | dm_req_i;
            sel      = (dm_req_i && !(if_req_i && starve_cnt_q == STARVE_TOP)) ? OWN_DM : OWN_IF;
        end else if (state_q == REQ) begin
            req_live = 1'b1;
        end
    end

    assign gnt_live = req_live && mem_gnt_i;
    assign rsp_fire = (state_q == WAIT) && mem_rvalid_i;
    assign if_owns  = (state_q == IDLE) ? (req_live && sel == OWN_IF) : (owner_q == OWN_IF);

    // Outputs are forced quiet while reset is held, even if requesters keep asserting.
    always_comb begin
        mem_req_o   = req_live && !rst_i;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            if (sel == OWN_DM) begin
                mem_we_o    = dm_we_i;
                mem_be_o    = dm_be_i;
                mem_addr_o  = dm_addr_i;
                mem_wdata_o = dm_wdata_i;
            end else begin
                mem_be_o    = '1;
                mem_addr_o  = if_addr_i;
            end
        end
    end

    assign if_gnt_o    = mem_req_o && mem_gnt_i && (sel == OWN_IF);
    assign dm_gnt_o    = mem_req_o && mem_gnt_i && (sel == OWN_DM);
    assign if_rvalid_o = rsp_fire && (owner_q == OWN_IF) && !drop_q && !if_flush_i;
    assign dm_rvalid_o = rsp_fire && (owner_q == OWN_DM);
    assign if_rdata_o  = mem_rdata_i;
    assign dm_rdata_o  = mem_rdata_i;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        drop_d       = drop_q;

        unique case (state_q)
            IDLE: begin
                if (req_live) begin
                    owner_d = sel;
                    state_d = mem_gnt_i ? WAIT : REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (gnt_live && sel == OWN_DM && if_req_i) begin
            if (starve_cnt_q != STARVE_TOP) starve_cnt_d = starve_cnt_q + SW'(1);
        end else if ((gnt_live && sel == OWN_IF) || (state_q == IDLE && !if_req_i)) begin
            starve_cnt_d = '0;
        end

        // Retiring the flushed response takes priority over a flush arriving in that cycle.
        if (rsp_fire && owner_q == OWN_IF) begin
            drop_d = 1'b0;
        end else if (if_flush_i && if_owns) begin
            drop_d = 1'b1;
        end
    end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: bench-driven memory handshakes, responses
// checked against a scoreboard of expected {destination, data} entries.
`timescale 1ns/1ps
module tb_riscv_mem_arbiter;
    localparam int W    = 32;
    localparam int SMAX = 4;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         if_req_i, if_flush_i, if_gnt_o, if_rvalid_o;
    logic [W-1:0] if_addr_i, if_rdata_o;
    logic         dm_req_i, dm_we_i, dm_gnt_o, dm_rvalid_o;
    logic [3:0]   dm_be_i;
    logic [W-1:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
    logic         mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [3:0]   mem_be_o;
    logic [W-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    typedef struct packed {
        logic         is_dm;
        logic [W-1:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   model_starve;
    logic exp_dm;
    logic dm_on;
    logic if_pend = 1'b0;
    logic dm_pend = 1'b0;

    always #5 clk_i = ~clk_i;

    riscv_mem_arbiter #(.WORD_SIZE(W), .STARVE_MAX(SMAX)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_flush_i  (if_flush_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_be_i     (dm_be_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_gnt_o    (dm_gnt_o),
        .dm_rvalid_o (dm_rvalid_o),
        .dm_rdata_o  (dm_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i)
    );

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic respond(input logic is_dm, input logic [W-1:0] data, input logic fwd);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = data;
        if (fwd) exp_q.push_back({is_dm, data});
    endtask

    task automatic quiet_inputs();
        if_req_i     = 1'b0;
        if_flush_i   = 1'b0;
        dm_req_i     = 1'b0;
        dm_we_i      = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
    endtask

    // Response monitor and requester-protocol guard.
    always @(negedge clk_i) begin
        if (if_rvalid_o || dm_rvalid_o) begin
            if (exp_q.size() == 0) begin
                check_eq("rsp_unexpected", 32'({if_rvalid_o, dm_rvalid_o}), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("rsp_if_valid", 32'(if_rvalid_o), 32'(!mon_e.is_dm));
                check_eq("rsp_dm_valid", 32'(dm_rvalid_o), 32'(mon_e.is_dm));
                check_eq("rsp_data", mon_e.is_dm ? dm_rdata_o : if_rdata_o, mon_e.data);
                $display("rsp %s data=0x%08h", mon_e.is_dm ? "DM" : "IF", mon_e.data);
            end
        end
        if (!rst_i && ((if_pend && !if_req_i) || (dm_pend && !dm_req_i)))
            $error("requester dropped req before gnt");
        if_pend = if_req_i && !if_gnt_o && !rst_i;
        dm_pend = dm_req_i && !dm_gnt_o && !rst_i;
    end

    initial begin
        rst_i = 1'b1;
        quiet_inputs();
        if_addr_i   = '0;
        dm_be_i     = '0;
        dm_addr_i   = '0;
        dm_wdata_i  = '0;
        mem_rdata_i = 32'h1234_5678;
        settle();
        check_eq("rst_mem_req", 32'(mem_req_o), 0);
        check_eq("rst_if_gnt", 32'(if_gnt_o), 0);
        check_eq("rst_dm_gnt", 32'(dm_gnt_o), 0);
        check_eq("rst_rvalids", 32'({if_rvalid_o, dm_rvalid_o}), 0);
        check_eq("rst_mem_addr", mem_addr_o, 0);
        check_eq("rst_mem_be", 32'(mem_be_o), 0);
        check_eq("rst_if_rdata", if_rdata_o, 32'h1234_5678);
        check_eq("rst_dm_rdata", dm_rdata_o, 32'h1234_5678);
        check_eq("rst_starve", 32'(dut.starve_cnt_q), 0);
        step();
        rst_i = 1'b0;

        // Single fetch, immediate grant, one-cycle response
        if_req_i = 1'b1; if_addr_i = 32'h100; mem_gnt_i = 1'b1;
        settle();
        check_eq("t1_if_gnt", 32'(if_gnt_o), 1);
        check_eq("t1_dm_gnt", 32'(dm_gnt_o), 0);
        check_eq("t1_mem_req", 32'(mem_req_o), 1);
        check_eq("t1_mem_addr", mem_addr_o, 32'h100);
        check_eq("t1_mem_we", 32'(mem_we_o), 0);
        check_eq("t1_mem_be", 32'(mem_be_o), 32'hF);
        check_eq("t1_mem_wdata", mem_wdata_o, 0);
        $display("txn IF addr=0x%08h granted", if_addr_i);
        step();
        if_req_i = 1'b0; mem_gnt_i = 1'b0;
        respond(1'b0, 32'hDEAD_BEEF, 1'b1);
        settle();
        check_eq("t1_if_rvalid", 32'(if_rvalid_o), 1);
        check_eq("t1_wait_no_req", 32'(mem_req_o), 0);
        step();
        mem_rvalid_i = 1'b0;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h1000; mem_gnt_i = 1'b1;
        settle();
        check_eq("t1_next_dm_gnt", 32'(dm_gnt_o), 1);
        check_eq("t1_next_addr", mem_addr_o, 32'h1000);
        step();
        dm_req_i = 1'b0; mem_gnt_i = 1'b0;
        respond(1'b1, 32'h0BAD_F00D, 1'b1);
        settle();
        step();
        mem_rvalid_i = 1'b0;

        // Both requesting: starvation counter forces IF through
        model_starve = 0;
        if_addr_i = 32'h200; dm_addr_i = 32'h3000;
        for (int i = 0; i < 7; i++) begin
            dm_on = (i < 6);
            if_req_i = 1'b1; dm_req_i = dm_on; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
            exp_dm = dm_on && (model_starve != SMAX);
            settle();
            check_eq($sformatf("t2_dm_gnt_%0d", i), 32'(dm_gnt_o), 32'(exp_dm));
            check_eq($sformatf("t2_if_gnt_%0d", i), 32'(if_gnt_o), 32'(!exp_dm));
            check_eq($sformatf("t2_addr_%0d", i), mem_addr_o, exp_dm ? 32'h3000 : 32'h200);
            $display("txn %s granted, if waiting", exp_dm ? "DM" : "IF");
            if (exp_dm) model_starve = (model_starve == SMAX) ? SMAX : model_starve + 1;
            else        model_starve = 0;
            step();
            mem_gnt_i = 1'b0;
            if (exp_dm) dm_req_i = 1'b0;
            else        if_req_i = 1'b0;
            respond(exp_dm, 32'hA000_0000 + W'(i), 1'b1);
            settle();
            check_eq($sformatf("t2_starve_%0d", i), 32'(dut.starve_cnt_q), W'(model_starve));
            step();
        end
        quiet_inputs();

        // Store stalled by memory; a late fetch must not steal the locked port
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'h3; dm_addr_i = 32'h2000; dm_wdata_i = 32'hCAFE_F00D;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                if_req_i = 1'b1; if_addr_i = 32'h300;
            end
            mem_gnt_i = (c == 3);
            settle();
            check_eq($sformatf("t3_req_%0d", c), 32'(mem_req_o), 1);
            check_eq($sformatf("t3_addr_%0d", c), mem_addr_o, 32'h2000);
            check_eq($sformatf("t3_we_%0d", c), 32'(mem_we_o), 1);
            check_eq($sformatf("t3_be_%0d", c), 32'(mem_be_o), 32'h3);
            check_eq($sformatf("t3_wdata_%0d", c), mem_wdata_o, 32'hCAFE_F00D);
            check_eq($sformatf("t3_dm_gnt_%0d", c), 32'(dm_gnt_o), 32'(c == 3));
            check_eq($sformatf("t3_if_gnt_%0d", c), 32'(if_gnt_o), 0);
            step();
        end
        $display("txn DM store addr=0x00002000 granted after stall");
        dm_req_i = 1'b0; dm_we_i = 1'b0; mem_gnt_i = 1'b0;
        respond(1'b1, 32'h0000_0000, 1'b1);
        settle();
        check_eq("t3_starve", 32'(dut.starve_cnt_q), 1);
        step();
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
        settle();
        check_eq("t3_if_gnt", 32'(if_gnt_o), 1);
        check_eq("t3_if_addr", mem_addr_o, 32'h300);
        check_eq("t3_if_be", 32'(mem_be_o), 32'hF);
        step();
        if_req_i = 1'b0; mem_gnt_i = 1'b0;
        respond(1'b0, 32'h3300_0000, 1'b1);
        settle();
        step();
        mem_rvalid_i = 1'b0;

        // Flush in WAIT, response two cycles later is swallowed
        if_req_i = 1'b1; if_addr_i = 32'h400; mem_gnt_i = 1'b1;
        settle();
        check_eq("t4_if_gnt", 32'(if_gnt_o), 1);
        step();
        if_req_i = 1'b0; mem_gnt_i = 1'b0; if_flush_i = 1'b1;
        settle();
        step();
        if_flush_i = 1'b0;
        settle();
        check_eq("t4_drop_set", 32'(dut.drop_q), 1);
        step();
        respond(1'b0, 32'h5555_AAAA, 1'b0);
        settle();
        check_eq("t4_swallowed", 32'(if_rvalid_o), 0);
        $display("txn IF addr=0x00000400 flushed");
        step();
        mem_rvalid_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h404; mem_gnt_i = 1'b1;
        settle();
        check_eq("t4_drop_clr", 32'(dut.drop_q), 0);
        check_eq("t4_refetch_gnt", 32'(if_gnt_o), 1);
        step();
        if_req_i = 1'b0; mem_gnt_i = 1'b0;
        respond(1'b0, 32'h0404_0404, 1'b1);
        settle();
        check_eq("t4_refetch_rvalid", 32'(if_rvalid_o), 1);
        // Flush coinciding with the response
        step();
        mem_rvalid_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h408; mem_gnt_i = 1'b1;
        settle();
        step();
        if_req_i = 1'b0; mem_gnt_i = 1'b0; if_flush_i = 1'b1;
        respond(1'b0, 32'h0408_0408, 1'b0);
        settle();
        check_eq("t4_same_cycle_rvalid", 32'(if_rvalid_o), 0);
        step();
        mem_rvalid_i = 1'b0; if_flush_i = 1'b0;
        settle();
        check_eq("t4_same_cycle_drop", 32'(dut.drop_q), 0);
        // Flush while DM owns the port has no effect
        step();
        dm_req_i = 1'b1; dm_addr_i = 32'h2004; mem_gnt_i = 1'b1;
        settle();
        check_eq("t4_dm_gnt", 32'(dm_gnt_o), 1);
        step();
        dm_req_i = 1'b0; mem_gnt_i = 1'b0; if_flush_i = 1'b1;
        respond(1'b1, 32'h7777_0000, 1'b1);
        settle();
        check_eq("t4_dm_rvalid", 32'(dm_rvalid_o), 1);
        step();
        if_flush_i = 1'b0; mem_rvalid_i = 1'b0;
        settle();
        check_eq("t4_dm_flush_drop", 32'(dut.drop_q), 0);

        // Reset while waiting for a response
        step();
        if_req_i = 1'b1; if_addr_i = 32'h40C; dm_req_i = 1'b1; dm_addr_i = 32'h2008; mem_gnt_i = 1'b1;
        settle();
        check_eq("t5_dm_gnt", 32'(dm_gnt_o), 1);
        step();
        if_req_i = 1'b0; dm_req_i = 1'b0; mem_gnt_i = 1'b0; rst_i = 1'b1;
        respond(1'b1, 32'h9999_0000, 1'b0);
        settle();
        check_eq("t5_mem_req", 32'(mem_req_o), 0);
        check_eq("t5_gnts", 32'({if_gnt_o, dm_gnt_o}), 0);
        check_eq("t5_rvalids", 32'({if_rvalid_o, dm_rvalid_o}), 0);
        check_eq("t5_starve", 32'(dut.starve_cnt_q), 0);
        check_eq("t5_rdata", dm_rdata_o, 32'h9999_0000);
        $display("txn DM addr=0x00002008 abandoned by reset");
        step();
        rst_i = 1'b0; mem_rvalid_i = 1'b0;
        settle();
        check_eq("t5_post_rst_req", 32'(mem_req_o), 0);

        // Stray rvalid in IDLE
        step();
        respond(1'b0, 32'hBEEF_0001, 1'b0);
        settle();
        check_eq("t6_rvalids", 32'({if_rvalid_o, dm_rvalid_o}), 0);
        check_eq("t6_mem_req", 32'(mem_req_o), 0);
        step();
        mem_rvalid_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h500; mem_gnt_i = 1'b1;
        settle();
        check_eq("t6_if_gnt", 32'(if_gnt_o), 1);
        step();
        if_req_i = 1'b0; mem_gnt_i = 1'b0;
        respond(1'b0, 32'h0500_0500, 1'b1);
        settle();
        check_eq("t6_if_rvalid", 32'(if_rvalid_o), 1);
        step();
        quiet_inputs();
        settle();
        check_eq("sb_empty", W'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
